// File: rtl/mx_fpga_id_pkg.sv
// rtl/mx_fpga_id_pkg.sv - shared types, register offsets and bit positions for the FPGA ID reader
package mx_fpga_id_pkg;

  typedef enum logic [2:0] {
    OPT_REQ,
    OPT_WAIT,
    IDLE,
    REQ,
    WAIT
  } state_e;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_OPT_VALID = 1;
  localparam int STAT_OVR       = 2;

  // CTRL and STATUS sit directly above the WPR data words.
  function automatic int ctrl_offset(input int wpr);
    return wpr;
  endfunction

  function automatic int status_offset(input int wpr);
    return wpr + 1;
  endfunction

  // AUTO_INC is the MSB of CTRL regardless of data width.
  function automatic int auto_inc_bit(input int dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/mx_fpga_id_rom_seq.sv
// rtl/mx_fpga_id_rom_seq.sv - ROM request pulse, read-latency counter and capture strobe
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   start    : one-cycle request from the owning FSM
//   rd_en    : ROM read request (forced low while reset is asserted)
//   done     : high in the cycle rom data is valid and must be captured
module mx_fpga_id_rom_seq #(
  parameter int ROM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic rd_en,
  output logic done
);

  localparam int CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  logic          active_q;
  logic [CW-1:0] cnt_q;

  // The FSM sits in a request state during reset; gating keeps the ROM quiet.
  assign rd_en = start & ~rst;
  assign done  = active_q && (cnt_q == CW'(ROM_LAT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
    end else if (done) begin
      active_q <= 1'b0;
    end else if (active_q) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mx_fpga_id_reader.sv
// rtl/mx_fpga_id_reader.sv - CSR-mapped reader for the FPGA ID/feature ROM with option preload
// Ports:
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   csr_addr_i/wr_en_i/wr_data_i : CSR write side, csr_be_i byte enables
//   csr_rd_en_i, csr_rd_data_o   : CSR read strobe (auto-increment) and combinational read data
//   rom_rd_en_o/rd_addr_o        : ROM request pulse and held address
//   rom_rd_data_i                : ROM data, valid ROM_LAT clocks after the request
//   options_o, options_valid_o   : preloaded option-mask words and their valid flag
//   busy_o                       : FSM not in IDLE
module mx_fpga_id_reader
  import mx_fpga_id_pkg::*;
#(
  parameter int                D_WIDTH   = 16,
  parameter int                A_WIDTH   = 10,
  parameter int                ROM_AW    = 8,
  parameter int                ROM_DW    = 32,
  parameter int                ROM_LAT   = 1,
  parameter logic [ROM_AW-1:0] OPT_BASE  = 8'hF0,
  parameter int                OPT_WORDS = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [A_WIDTH-1:0]          csr_addr_i,
  input  logic                        csr_wr_en_i,
  input  logic [D_WIDTH-1:0]          csr_wr_data_i,
  input  logic [D_WIDTH/8-1:0]        csr_be_i,
  input  logic                        csr_rd_en_i,
  output logic [D_WIDTH-1:0]          csr_rd_data_o,
  output logic                        rom_rd_en_o,
  output logic [ROM_AW-1:0]           rom_rd_addr_o,
  input  logic [ROM_DW-1:0]           rom_rd_data_i,
  output logic [OPT_WORDS*ROM_DW-1:0] options_o,
  output logic                        options_valid_o,
  output logic                        busy_o
);

  localparam int WPR = ROM_DW / D_WIDTH;
  localparam int BW  = D_WIDTH / 8;
  localparam int OCW = $clog2(OPT_WORDS + 1);
  localparam logic [A_WIDTH-1:0] CTRL_A = A_WIDTH'(ctrl_offset(WPR));
  localparam logic [A_WIDTH-1:0] STAT_A = A_WIDTH'(status_offset(WPR));
  localparam logic [A_WIDTH-1:0] LAST_A = A_WIDTH'(WPR - 1);
  localparam logic [D_WIDTH-1:0] CTRL_MASK =
    (D_WIDTH'(1) << auto_inc_bit(D_WIDTH)) | D_WIDTH'((1 << ROM_AW) - 1);

  state_e                      state_q, state_d;
  logic [D_WIDTH-1:0]          ctrl_q, ctrl_d;
  logic [ROM_DW-1:0]           data_q;
  logic [OPT_WORDS*ROM_DW-1:0] opt_q;
  logic [OCW-1:0]              opt_cnt_q;
  logic                        opt_valid_q, ovr_q, pend_q;
  logic [ROM_AW-1:0]           addr_q;
  logic                        seq_start, seq_done, load_addr, opt_cap, data_cap;
  logic                        idle, wr_ctrl, rd_last, auto_inc, trigger, ovr_clr;

  assign idle     = (state_q == IDLE);
  assign wr_ctrl  = csr_wr_en_i && (csr_addr_i == CTRL_A) && (|csr_be_i);
  assign rd_last  = csr_rd_en_i && (csr_addr_i == LAST_A) && ctrl_q[auto_inc_bit(D_WIDTH)];
  assign auto_inc = rd_last && idle;
  assign trigger  = wr_ctrl || auto_inc || pend_q;
  assign ovr_clr  = csr_wr_en_i && (csr_addr_i == STAT_A) && csr_be_i[0]
                    && csr_wr_data_i[STAT_OVR];

  // A write beats an auto-increment in the same cycle; both fetch at the new PTR.
  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl) begin
      for (int b = 0; b < BW; b++)
        if (csr_be_i[b])
          ctrl_d[b*8 +: 8] = csr_wr_data_i[b*8 +: 8] & CTRL_MASK[b*8 +: 8];
    end else if (auto_inc) begin
      ctrl_d[ROM_AW-1:0] = ctrl_q[ROM_AW-1:0] + ROM_AW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    seq_start = 1'b0;
    load_addr = 1'b0;
    opt_cap   = 1'b0;
    data_cap  = 1'b0;
    case (state_q)
      OPT_REQ: begin
        seq_start = 1'b1;
        state_d   = OPT_WAIT;
      end
      OPT_WAIT: if (seq_done) begin
        opt_cap = 1'b1;
        state_d = (opt_cnt_q == OCW'(OPT_WORDS - 1)) ? IDLE : OPT_REQ;
      end
      IDLE: if (trigger) begin
        load_addr = 1'b1;
        state_d   = REQ;
      end
      REQ: begin
        seq_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: if (seq_done) begin
        data_cap = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = OPT_REQ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= OPT_REQ;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q      <= '0;
      data_q      <= '0;
      opt_q       <= '0;
      opt_cnt_q   <= '0;
      opt_valid_q <= 1'b0;
      ovr_q       <= 1'b0;
      pend_q      <= 1'b0;
      addr_q      <= OPT_BASE;
    end else begin
      ctrl_q <= ctrl_d;
      if (data_cap) data_q <= rom_rd_data_i;
      if (opt_cap) begin
        for (int k = 0; k < OPT_WORDS; k++)
          if (opt_cnt_q == OCW'(k)) opt_q[k*ROM_DW +: ROM_DW] <= rom_rd_data_i;
        opt_cnt_q <= opt_cnt_q + OCW'(1);
        if (opt_cnt_q == OCW'(OPT_WORDS - 1)) opt_valid_q <= 1'b1;
      end
      if (opt_cap)        addr_q <= addr_q + ROM_AW'(1);
      else if (load_addr) addr_q <= ctrl_d[ROM_AW-1:0];
      // Pending collapses any number of busy-time CTRL writes into one fetch.
      if (load_addr)             pend_q <= 1'b0;
      else if (wr_ctrl && !idle) pend_q <= 1'b1;
      if (rd_last && !idle) ovr_q <= 1'b1;
      else if (ovr_clr)     ovr_q <= 1'b0;
    end
  end

  mx_fpga_id_rom_seq #(.ROM_LAT(ROM_LAT)) u_seq (
    .clk   (clk_i),
    .rst   (rst_i),
    .start (seq_start),
    .rd_en (rom_rd_en_o),
    .done  (seq_done)
  );

  always_comb begin
    csr_rd_data_o = '0;
    for (int k = 0; k < WPR; k++)
      if (csr_addr_i == A_WIDTH'(k)) csr_rd_data_o = data_q[k*D_WIDTH +: D_WIDTH];
    if (csr_addr_i == CTRL_A) csr_rd_data_o = ctrl_q;
    if (csr_addr_i == STAT_A) begin
      csr_rd_data_o[STAT_BUSY]      = busy_o;
      csr_rd_data_o[STAT_OPT_VALID] = opt_valid_q;
      csr_rd_data_o[STAT_OVR]       = ovr_q;
    end
  end

  assign rom_rd_addr_o   = addr_q;
  assign options_o       = opt_q;
  assign options_valid_o = opt_valid_q;
  assign busy_o          = !idle;

endmodule
